// File: rtl/iterative_divider.sv
// Restoring shift-subtract divider: one quotient bit per clock, signed/unsigned,
// with destination tags carried through and OV/S/Z flags for the PSW.
module iterative_divider #(
   parameter int WIDTH = 32,
   parameter int REG_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic               flush_i,
   input  logic [WIDTH-1:0]   dividend_i,
   input  logic [WIDTH-1:0]   divisor_i,
   input  logic [REG_W-1:0]   dest_q_i,
   input  logic [REG_W-1:0]   dest_r_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [WIDTH-1:0]   quotient_o,
   output logic [WIDTH-1:0]   remainder_o,
   output logic [REG_W-1:0]   dest_q_o,
   output logic [REG_W-1:0]   dest_r_o,
   output logic               ov_o,
   output logic               s_o,
   output logic               z_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t            state, state_next;
   logic [CW-1:0]     count;
   logic [WIDTH-1:0]  quo_q;
   logic [WIDTH-1:0]  rem_q;
   logic [WIDTH-1:0]  div_q;
   logic              q_neg, r_neg, ov_q;
   logic [REG_W-1:0]  tag_q, tag_r;

   logic              accept, div_zero, sig_ovf, special;
   logic [WIDTH-1:0]  a_abs, b_abs, q_fix, r_fix;
   logic [WIDTH:0]    partial, diff;

   always_comb begin
      accept   = (state == IDLE) && start_i && !flush_i;
      div_zero = (divisor_i == '0);
      sig_ovf  = signed_i && (dividend_i == MIN_NEG) && (&divisor_i);
      special  = div_zero || sig_ovf;
      a_abs    = (signed_i && dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
      b_abs    = (signed_i && divisor_i[WIDTH-1])  ? -divisor_i  : divisor_i;
      partial  = {rem_q, quo_q[WIDTH-1]};
      diff     = partial - {1'b0, div_q};
      q_fix    = q_neg ? -quo_q : quo_q;
      r_fix    = r_neg ? -rem_q : rem_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Flush wins over start in IDLE and cancels CALC/FIX without a done pulse.
   always_comb begin
      state_next = state;
      busy_o     = (state != IDLE);
      case (state)
         IDLE: if (accept) state_next = special ? FIX : CALC;
         CALC: begin
            if (flush_i)             state_next = IDLE;
            else if (count == '0)    state_next = FIX;
         end
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         ov_q        <= 1'b0;
         tag_q       <= '0;
         tag_r       <= '0;
         done_o      <= 1'b0;
         quotient_o  <= '0;
         remainder_o <= '0;
         dest_q_o    <= '0;
         dest_r_o    <= '0;
         ov_o        <= 1'b0;
         s_o         <= 1'b0;
         z_o         <= 1'b0;
      end else begin
         done_o <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               tag_q <= dest_q_i;
               tag_r <= dest_r_i;
               count <= LAST_STEP;
               div_q <= b_abs;
               // Special cases preload the final magnitudes and skip the iteration.
               if (div_zero) begin
                  quo_q <= '0;
                  rem_q <= dividend_i;
                  q_neg <= 1'b0;
                  r_neg <= 1'b0;
                  ov_q  <= 1'b1;
               end else if (sig_ovf) begin
                  quo_q <= MIN_NEG;
                  rem_q <= '0;
                  q_neg <= 1'b0;
                  r_neg <= 1'b0;
                  ov_q  <= 1'b1;
               end else begin
                  quo_q <= a_abs;
                  rem_q <= '0;
                  q_neg <= signed_i && (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                  r_neg <= signed_i && dividend_i[WIDTH-1];
                  ov_q  <= 1'b0;
               end
            end
            CALC: if (!flush_i) begin
               count <= count - 1'b1;
               if (!diff[WIDTH]) begin
                  rem_q <= diff[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= partial[WIDTH-1:0];
                  quo_q <= {quo_q[WIDTH-2:0], 1'b0};
               end
            end
            FIX: if (!flush_i) begin
               done_o      <= 1'b1;
               quotient_o  <= q_fix;
               remainder_o <= r_fix;
               dest_q_o    <= tag_q;
               dest_r_o    <= tag_r;
               ov_o        <= ov_q;
               s_o         <= q_fix[WIDTH-1];
               z_o         <= (q_fix == '0);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed-vector bench for iterative_divider: a 32-bit instance for the
// main scenarios and a 16-bit instance for the parametrised cases.
module tb_iterative_divider;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        start, sgn, flush;
   logic [31:0] a, b;
   logic [4:0]  dq, dr;
   logic        busy, done, ov, s, z;
   logic [31:0] q, r;
   logic [4:0]  tq, tr;

   logic        h_start, h_sgn, h_flush;
   logic [15:0] h_a, h_b;
   logic [4:0]  h_dq, h_dr;
   logic        h_busy, h_done, h_ov, h_s, h_z;
   logic [15:0] h_q, h_r;
   logic [4:0]  h_tq, h_tr;

   int compared   = 0;
   int mismatched = 0;

   iterative_divider #(.WIDTH(32), .REG_W(5)) dut (
      .clk(clk), .rst(rst), .start_i(start), .signed_i(sgn), .flush_i(flush),
      .dividend_i(a), .divisor_i(b), .dest_q_i(dq), .dest_r_i(dr),
      .busy_o(busy), .done_o(done), .quotient_o(q), .remainder_o(r),
      .dest_q_o(tq), .dest_r_o(tr), .ov_o(ov), .s_o(s), .z_o(z)
   );

   iterative_divider #(.WIDTH(16), .REG_W(5)) dut16 (
      .clk(clk), .rst(rst), .start_i(h_start), .signed_i(h_sgn), .flush_i(h_flush),
      .dividend_i(h_a), .divisor_i(h_b), .dest_q_i(h_dq), .dest_r_i(h_dr),
      .busy_o(h_busy), .done_o(h_done), .quotient_o(h_q), .remainder_o(h_r),
      .dest_q_o(h_tq), .dest_r_o(h_tr), .ov_o(h_ov), .s_o(h_s), .z_o(h_z)
   );

   // Presents an operation at the falling edge and holds start across one rising edge.
   task automatic start_op(input logic sv, input logic [31:0] av, input logic [31:0] bv,
                           input logic [4:0] qt, input logic [4:0] rt);
      @(negedge clk);
      sgn = sv; a = av; b = bv; dq = qt; dr = rt; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk);
         cyc++;
         #1;
      end while (!done && cyc < 100);
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      compared++; if ({busy, done, ov, s, z} !== 5'b0) begin mismatched++; $display("[TB] FAIL reset_flags: got %b want 00000", {busy, done, ov, s, z}); end
      compared++; if ({q, r, tq, tr} !== 74'b0) begin mismatched++; $display("[TB] FAIL reset_data: got q=%h r=%h tq=%0d tr=%0d want all zero", q, r, tq, tr); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_unsigned();
      int cyc;
      start_op(1'b0, 32'd100, 32'd7, 5'd3, 5'd4);
      compared++; if (busy !== 1'b1) begin mismatched++; $display("[TB] FAIL unsigned_busy: got %b want 1", busy); end
      wait_done(cyc);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL unsigned_latency: got %0d want 33", cyc); end
      compared++; if ({q, r} !== {32'd14, 32'd2}) begin mismatched++; $display("[TB] FAIL unsigned_result: got q=%0d r=%0d want q=14 r=2", q, r); end
      compared++; if ({tq, tr} !== {5'd3, 5'd4}) begin mismatched++; $display("[TB] FAIL unsigned_tags: got %0d/%0d want 3/4", tq, tr); end
      compared++; if ({ov, s, z, busy} !== 4'b0000) begin mismatched++; $display("[TB] FAIL unsigned_flags: got ov/s/z/busy=%b want 0000", {ov, s, z, busy}); end
      @(posedge clk); #1;
      compared++; if (done !== 1'b0) begin mismatched++; $display("[TB] FAIL done_pulse_width: got %b want 0", done); end
   endtask

   task automatic test_signed();
      int cyc;
      start_op(1'b1, -32'sd7, 32'd2, 5'd1, 5'd2);
      wait_done(cyc);
      compared++; if ({q, r} !== {32'hFFFFFFFD, 32'hFFFFFFFF}) begin mismatched++; $display("[TB] FAIL signed_neg_dividend: got q=%h r=%h want q=fffffffd r=ffffffff", q, r); end
      compared++; if ({ov, s, z} !== 3'b010) begin mismatched++; $display("[TB] FAIL signed_neg_flags: got ov/s/z=%b want 010", {ov, s, z}); end
      start_op(1'b1, 32'd7, -32'sd2, 5'd5, 5'd6);
      wait_done(cyc);
      compared++; if ({q, r} !== {32'hFFFFFFFD, 32'd1}) begin mismatched++; $display("[TB] FAIL signed_neg_divisor: got q=%h r=%h want q=fffffffd r=1", q, r); end
   endtask

   task automatic test_div_zero();
      int cyc;
      start_op(1'b1, 32'h12345678, 32'd0, 5'd8, 5'd9);
      wait_done(cyc);
      compared++; if (cyc !== 1) begin mismatched++; $display("[TB] FAIL divzero_latency: got %0d want 1", cyc); end
      compared++; if ({q, r} !== {32'd0, 32'h12345678}) begin mismatched++; $display("[TB] FAIL divzero_result: got q=%h r=%h want q=0 r=12345678", q, r); end
      compared++; if ({ov, s, z} !== 3'b101) begin mismatched++; $display("[TB] FAIL divzero_flags: got ov/s/z=%b want 101", {ov, s, z}); end
   endtask

   task automatic test_overflow();
      int cyc;
      start_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd10, 5'd11);
      wait_done(cyc);
      compared++; if (cyc !== 1) begin mismatched++; $display("[TB] FAIL sovf_latency: got %0d want 1", cyc); end
      compared++; if ({q, r, ov, s, z} !== {32'h80000000, 32'd0, 3'b110}) begin mismatched++; $display("[TB] FAIL sovf_result: got q=%h r=%h ov/s/z=%b want 80000000/0/110", q, r, {ov, s, z}); end
      start_op(1'b0, 32'h80000000, 32'hFFFFFFFF, 5'd12, 5'd13);
      wait_done(cyc);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL uovf_latency: got %0d want 33", cyc); end
      compared++; if ({q, r, ov, s, z} !== {32'd0, 32'h80000000, 3'b001}) begin mismatched++; $display("[TB] FAIL uovf_result: got q=%h r=%h ov/s/z=%b want 0/80000000/001", q, r, {ov, s, z}); end
   endtask

   task automatic test_start_busy();
      int cyc;
      start_op(1'b0, 32'd100, 32'd7, 5'd3, 5'd4);
      repeat (5) @(posedge clk);
      #1 begin a = 32'd999; b = 32'd1; dq = 5'd20; start = 1'b1; end
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(cyc);
      compared++; if (cyc !== 27) begin mismatched++; $display("[TB] FAIL busy_start_latency: got %0d want 27", cyc); end
      compared++; if ({q, r, tq, tr} !== {32'd14, 32'd2, 5'd3, 5'd4}) begin mismatched++; $display("[TB] FAIL busy_start_result: got q=%0d r=%0d tags=%0d/%0d want 14/2/3/4", q, r, tq, tr); end
   endtask

   task automatic test_flush();
      int seen;
      start_op(1'b0, 32'd1000, 32'd3, 5'd21, 5'd22);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("[TB] FAIL flush_busy: got busy/done=%b want 00", {busy, done}); end
      seen = 0;
      repeat (40) begin @(posedge clk); #1; if (done) seen++; end
      compared++; if (seen !== 0) begin mismatched++; $display("[TB] FAIL flush_no_done: got %0d done pulses want 0", seen); end
      compared++; if ({q, r, tq, tr} !== {32'd14, 32'd2, 5'd3, 5'd4}) begin mismatched++; $display("[TB] FAIL flush_hold: got q=%0d r=%0d tags=%0d/%0d want 14/2/3/4", q, r, tq, tr); end
      @(negedge clk);
      a = 32'd9; b = 32'd3; start = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 begin start = 1'b0; flush = 1'b0; end
      compared++; if (busy !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_idle_priority: got busy=%b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int cyc;
      start_op(1'b0, 32'd50, 32'd6, 5'd1, 5'd2);
      wait_done(cyc);
      compared++; if ({done, busy, q, r} !== {2'b10, 32'd8, 32'd2}) begin mismatched++; $display("[TB] FAIL b2b_first: got done/busy=%b q=%0d r=%0d want 10/8/2", {done, busy}, q, r); end
      sgn = 1'b0; a = 32'd81; b = 32'd9; dq = 5'd30; dr = 5'd31; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(cyc);
      compared++; if (cyc !== 33) begin mismatched++; $display("[TB] FAIL b2b_latency: got %0d want 33", cyc); end
      compared++; if ({q, r, tq, tr} !== {32'd9, 32'd0, 5'd30, 5'd31}) begin mismatched++; $display("[TB] FAIL b2b_second: got q=%0d r=%0d tags=%0d/%0d want 9/0/30/31", q, r, tq, tr); end
   endtask

   task automatic test_reset_mid();
      int cyc;
      start_op(1'b0, 32'd12345, 32'd11, 5'd7, 5'd8);
      repeat (10) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      compared++; if ({busy, done, ov, s, z, q, r, tq, tr} !== 79'b0) begin mismatched++; $display("[TB] FAIL reset_mid: got busy=%b q=%h r=%h tags=%0d/%0d flags=%b want all zero", busy, q, r, tq, tr, {ov, s, z}); end
      @(negedge clk) rst = 1'b0;
      start_op(1'b0, 32'hFFFFFFFF, 32'h10, 5'd7, 5'd9);
      wait_done(cyc);
      compared++; if ({cyc == 33, q, r} !== {1'b1, 32'h0FFFFFFF, 32'hF}) begin mismatched++; $display("[TB] FAIL reset_recover: got lat=%0d q=%h r=%h want 33/0fffffff/f", cyc, q, r); end
   endtask

   task automatic test_width16();
      int cyc;
      @(negedge clk);
      h_sgn = 1'b1; h_a = 16'h8000; h_b = 16'hFFFF; h_dq = 5'd2; h_dr = 5'd3; h_start = 1'b1;
      @(posedge clk);
      #1 h_start = 1'b0;
      cyc = 0;
      do begin @(posedge clk); cyc++; #1; end while (!h_done && cyc < 100);
      compared++; if ({cyc == 1, h_q, h_r, h_ov, h_s} !== {1'b1, 16'h8000, 16'h0, 2'b11}) begin mismatched++; $display("[TB] FAIL w16_sovf: got lat=%0d q=%h r=%h ov/s=%b want 1/8000/0/11", cyc, h_q, h_r, {h_ov, h_s}); end
      @(negedge clk);
      h_sgn = 1'b0; h_a = 16'd65535; h_b = 16'd255; h_start = 1'b1;
      @(posedge clk);
      #1 h_start = 1'b0;
      cyc = 0;
      do begin @(posedge clk); cyc++; #1; end while (!h_done && cyc < 100);
      compared++; if (cyc !== 17) begin mismatched++; $display("[TB] FAIL w16_latency: got %0d want 17", cyc); end
      compared++; if ({h_q, h_r, h_ov} !== {16'd257, 16'd0, 1'b0}) begin mismatched++; $display("[TB] FAIL w16_unsigned: got q=%0d r=%0d ov=%b want 257/0/0", h_q, h_r, h_ov); end
   endtask

   initial begin
      start = 1'b0; sgn = 1'b0; flush = 1'b0; a = '0; b = '0; dq = '0; dr = '0;
      h_start = 1'b0; h_sgn = 1'b0; h_flush = 1'b0; h_a = '0; h_b = '0; h_dq = '0; h_dr = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_overflow();
      test_start_busy();
      test_flush();
      test_back_to_back();
      test_reset_mid();
      test_width16();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
